// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// alu_sequencer : fetch/execute controller driving the shared 8-bit ALU
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int PC_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic            mem_req,
   output logic [PC_W-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [7:0]      mem_data,
   output logic [1:0]      alu_opcode,
   output logic [3:0]      alu_addrs,
   output logic [7:0]      alu_dIn0,
   output logic [7:0]      alu_dIn1,
   input  logic            alu_carry,
   input  logic            alu_borrow,
   input  logic            alu_bcf,
   input  logic            alu_bbf,
   input  logic            alu_buc,
   input  logic            alu_toggle,
   input  logic [7:0]      alu_dOut,
   output logic            toggle_q,
   output logic [7:0]      dbg_r3,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_FETCH     = 2'd1,
      S_FETCH_IMM = 2'd2,
      S_EXEC      = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] C_PC_ONE = PC_W'(1);
   localparam logic [1:0]      C_OP_ADD = 2'd0;
   localparam logic [1:0]      C_OP_SUB = 2'd1;
   localparam logic [1:0]      C_OP_MOV = 2'd3;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [7:0]      r_ir;
   logic [7:0]      r_imm;
   logic [7:0]      r_regs [4];
   logic            r_c;
   logic            r_b;
   logic            r_toggle;

   logic [1:0]      w_op;
   logic [1:0]      w_rd;
   logic [1:0]      w_rs;
   logic [1:0]      w_rm;
   logic            w_branch;
   logic            w_taken;
   logic            w_exec;

   assign w_op     = r_ir[7:6];
   assign w_rd     = r_ir[5:4];
   assign w_rs     = r_ir[3:2];
   assign w_rm     = r_ir[1:0];
   assign w_exec   = (r_state == S_EXEC);
   assign w_branch = alu_bcf | alu_bbf | alu_buc;
   assign w_taken  = alu_buc | (alu_bcf & r_c) | (alu_bbf & r_b);

   assign mem_req    = (r_state == S_FETCH) || (r_state == S_FETCH_IMM);
   assign mem_addr   = r_pc;
   assign busy       = (r_state != S_IDLE);
   assign alu_opcode = r_ir[7:6];
   assign alu_addrs  = r_ir[5:2];
   assign toggle_q   = r_toggle;
   assign dbg_r3     = r_regs[3];

   // Operands are forced to zero outside EXEC so the ALU sees a quiet bus.
   assign alu_dIn0 = (w_exec && (w_op != C_OP_MOV)) ? r_regs[w_rd] : 8'h00;
   assign alu_dIn1 = !w_exec                ? 8'h00 :
                     (w_op == C_OP_MOV)     ? r_imm : r_regs[w_rs];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_ir     <= '0;
         r_imm    <= '0;
         r_c      <= 1'b0;
         r_b      <= 1'b0;
         r_toggle <= 1'b0;
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (mem_ack) begin
                  r_ir    <= mem_data;
                  r_pc    <= r_pc + C_PC_ONE;
                  r_state <= (mem_data[7:6] == C_OP_MOV) ? S_FETCH_IMM : S_EXEC;
               end
            end
            S_FETCH_IMM: begin
               if (mem_ack) begin
                  r_imm   <= mem_data;
                  r_pc    <= r_pc + C_PC_ONE;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_op == C_OP_MOV) begin
                  // Any branch flag turns the two-byte op into a branch with no write-back.
                  if (!w_branch)    r_regs[w_rm] <= alu_dOut;
                  else if (w_taken) r_pc         <= r_imm[PC_W-1:0];
               end else begin
                  r_regs[w_rd] <= alu_dOut;
                  if (w_op == C_OP_ADD) r_c <= alu_carry;
                  if (w_op == C_OP_SUB) r_b <= alu_borrow;
               end
               if (alu_toggle) r_toggle <= ~r_toggle;
               r_state <= run ? S_FETCH : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
